mmio_sample_fifo_core: RTL and testbench
========================================

# mmio_sample_fifo_core

MMIO responder slot that buffers a 32-bit sample stream and lets the MicroBlaze MCS drain it through the MMIO bus. It sits inside `mmio_top` as one slot behind `io_mmio_bridge`. The bridge is the initiator; this core answers its chip-select/read/write strobes. Samples arrive on a valid/ready stream, for example from the audio receive path already in the `i_clk` domain. The core adds level, overflow and threshold status.

## Interface
- `DEPTH_LOG2`, default 9: FIFO depth is 2^DEPTH_LOG2 words (512).
- `i_clk`  in  1: system clock; single clock domain.
- `i_reset_n`  in  1: asynchronous, active-low reset.
- `i_mmio_cs`  in  1: slot select from the MMIO decoder.
- `i_mmio_write`  in  1: write strobe; one cycle per access.
- `i_mmio_read`  in  1: read strobe; one cycle per access.
- `i_mmio_addr`  in  5: register index within the slot.
- `i_mmio_write_data`  in  32: write data.
- `o_mmio_read_data`  out  32: read data; combinational from `i_mmio_addr`.
- `i_sample_valid`  in  1: stream input valid.
- `i_sample_data`  in  32: stream input word.
- `o_sample_ready`  out  1: equals enable && !full.
- `o_irq`  out  1: registered; high while enable && level >= threshold && threshold != 0.

## Operation
- Register map, by `i_mmio_addr`:
  - 0 DATA (R): head word of the FIFO. A cs&read with the FIFO non-empty pops one word. A cs&read on an empty FIFO returns 0 and does not pop.
  - 1 STATUS (R): [DEPTH_LOG2:0] level, [16] empty, [17] full, [18] overflow (sticky), [19] irq.
  - 2 CTRL (R/W): [0] enable. Writing bit [31]=1 flushes the FIFO (level→0); bit 31 is self-clearing and reads as 0.
  - 3 THRESH (R/W): [DEPTH_LOG2:0] threshold; upper bits are ignored on write and read as 0.
  - 4 CLEAR (W): any write clears overflow.
  - Reads of unmapped indices and of CLEAR return 0. Writes to read-only or unmapped indices are ignored.
- Push:
  - A push occurs when `i_sample_valid && o_sample_ready`.
  - If enable && full && `i_sample_valid`, the sample is dropped and overflow is set.
  - While enable=0, input is ignored and overflow is not set.
- Simultaneous push and pop: both take effect and level is unchanged.
  - When full, ready is low, so the push is refused and overflow is set. That word is lost even though a pop frees a slot.
  - When empty, the read returns 0, there is no pop, and the push lands.
- Flush has priority over push and pop in the same cycle; the pushed word is discarded. Flush does not clear overflow.
- Write-side effects require `i_mmio_cs`. Strobes with cs=0 do nothing.

## Timing
- Reset values:
  - level 0, enable 0, threshold 0, overflow 0.
  - `o_irq` 0, `o_sample_ready` 0.
  - `o_mmio_read_data` reflects the reset registers (STATUS = 0x0001_0000).
- Read latency: `o_mmio_read_data` is valid in the same cycle as cs&read; the bridge samples it combinationally.
- A pop updates the head and level at the next rising edge. Back-to-back DATA reads on consecutive cycles return consecutive words.
- A push is visible in DATA/STATUS 1 cycle after the accepting edge (first-word fall-through).
- CTRL/THRESH writes take effect at the next edge. `o_sample_ready` follows enable and full one cycle after the write.
- `o_irq` is registered and lags the level/threshold condition by 1 cycle.
- Reset asserted mid-operation clears everything immediately. In-flight samples are lost and no spurious pop occurs after release.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. Level is DEPTH_LOG2+1 bits and spans 0..2^DEPTH_LOG2.

## Structure
- Shared `mmio_pkg` holds:
  - register index constants `REG_DATA`, `REG_STATUS`, `REG_CTRL`, `REG_THRESH`, `REG_CLEAR`;
  - STATUS bit positions;
  - the CTRL flush bit index.
- One sub-module, `fifo_fwft`:
  - parameterised depth and 32-bit width;
  - push/pop/flush inputs; head, level, empty and full outputs;
  - memory inferred as distributed/LUT RAM so the head is readable asynchronously.
- The core itself holds the address decode, control registers, overflow sticky, irq register and read mux.

## Test plan
- Reset, then read STATUS → 0x0001_0000; `o_sample_ready`=0 and `o_irq`=0.
- Write CTRL=1, push 0xA5A5_0001..0xA5A5_0003 → STATUS level=3; three DATA reads return the words in order; a fourth DATA read returns 0 with level still 0.
- Enable, push 512 words, then assert valid one more cycle:
  - full=1 and `o_sample_ready`=0;
  - overflow=1 and level stays 512;
  - a write to CLEAR sets overflow to 0.
- THRESH=4: `o_irq` rises 1 cycle after the 4th push; one DATA read drops level to 3 and `o_irq` falls 1 cycle later.
- Push and DATA read in the same cycle at level 2 → level stays 2; the read returns the old head.
- Write CTRL=0x8000_0001 while a push is concurrent → level=0, the head is discarded, enable stays 1 and CTRL reads back 0x0000_0001.

Source files
------------

// File: rtl/mmio_sample_fifo_core_pkg.sv
// Shared MMIO definitions: register indices, STATUS/CTRL bit positions and the STATUS packing helper.
package mmio_pkg;

  localparam logic [4:0] REG_DATA   = 5'd0;
  localparam logic [4:0] REG_STATUS = 5'd1;
  localparam logic [4:0] REG_CTRL   = 5'd2;
  localparam logic [4:0] REG_THRESH = 5'd3;
  localparam logic [4:0] REG_CLEAR  = 5'd4;

  localparam int STAT_EMPTY_BIT = 16;
  localparam int STAT_FULL_BIT  = 17;
  localparam int STAT_OVF_BIT   = 18;
  localparam int STAT_IRQ_BIT   = 19;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_FLUSH_BIT = 31;

  typedef struct packed {
    logic irq;
    logic overflow;
    logic full;
    logic empty;
  } status_flags_t;

  // Level occupies the low half-word; flags sit at fixed positions above it.
  function automatic logic [31:0] pack_status(input logic [15:0] level, input status_flags_t flags);
    logic [31:0] status;
    status                 = 32'd0;
    status[15:0]           = level;
    status[STAT_EMPTY_BIT] = flags.empty;
    status[STAT_FULL_BIT]  = flags.full;
    status[STAT_OVF_BIT]   = flags.overflow;
    status[STAT_IRQ_BIT]   = flags.irq;
    return status;
  endfunction

endpackage

// File: rtl/mmio_sample_fifo_core_if.sv
// MMIO slot bus plus the sample stream feeding the FIFO core.
interface mmio_sample_fifo_core_if;
  logic        i_mmio_cs;
  logic        i_mmio_write;
  logic        i_mmio_read;
  logic [4:0]  i_mmio_addr;
  logic [31:0] i_mmio_write_data;
  logic [31:0] o_mmio_read_data;
  logic        i_sample_valid;
  logic [31:0] i_sample_data;
  logic        o_sample_ready;

  modport master (
    output i_mmio_cs, i_mmio_write, i_mmio_read, i_mmio_addr, i_mmio_write_data,
    output i_sample_valid, i_sample_data,
    input  o_mmio_read_data, o_sample_ready
  );

  modport slave (
    input  i_mmio_cs, i_mmio_write, i_mmio_read, i_mmio_addr, i_mmio_write_data,
    input  i_sample_valid, i_sample_data,
    output o_mmio_read_data, o_sample_ready
  );
endinterface

// File: rtl/mmio_sample_fifo_core_fifo_fwft.sv
// First-word-fall-through FIFO; the head is read asynchronously so the memory maps onto LUT RAM.
module fifo_fwft #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  flush,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      head,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2:0]   level_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  // Flush overrides both sides, so a word pushed in that cycle is discarded.
  assign do_push_s = push & ~full & ~flush;
  assign do_pop_s  = pop & ~empty & ~flush;

  assign empty = (level_r == {(DEPTH_LOG2+1){1'b0}});
  assign full  = level_r[DEPTH_LOG2];
  assign level = level_r;
  assign head  = mem_r[rd_ptr_r];

  // Storage write port (no reset so it stays a plain RAM).
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and level bookkeeping; pointers wrap naturally at depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      level_r  <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/mmio_sample_fifo_core.sv
// MMIO slot that buffers a 32-bit sample stream for the MCS to drain, with level/overflow/threshold status.
module mmio_sample_fifo_core
  import mmio_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  mmio_sample_fifo_core_if.slave  bus,
  output logic                    o_irq
);

  logic                  enable_r;
  logic [DEPTH_LOG2:0]   thresh_r;
  logic                  overflow_r;
  logic                  irq_r;

  logic [31:0]           head_s;
  logic [DEPTH_LOG2:0]   level_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  wr_s;
  logic                  rd_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  flush_s;
  logic                  ctrl_wr_s;
  logic                  thresh_wr_s;
  logic                  clear_wr_s;
  logic                  ovf_set_s;
  logic                  irq_cond_s;
  logic [31:0]           rdata_s;
  status_flags_t         flags_s;
  logic                  unused_wdata_s;

  assign wr_s        = bus.i_mmio_cs & bus.i_mmio_write;
  assign rd_s        = bus.i_mmio_cs & bus.i_mmio_read;
  assign ctrl_wr_s   = wr_s & (bus.i_mmio_addr == REG_CTRL);
  assign thresh_wr_s = wr_s & (bus.i_mmio_addr == REG_THRESH);
  assign clear_wr_s  = wr_s & (bus.i_mmio_addr == REG_CLEAR);
  assign flush_s     = ctrl_wr_s & bus.i_mmio_write_data[CTRL_FLUSH_BIT];
  assign pop_s       = rd_s & (bus.i_mmio_addr == REG_DATA) & ~empty_s;
  assign push_s      = bus.i_sample_valid & bus.o_sample_ready;
  // A sample offered while enabled but full is lost; with enable low nothing counts as a drop.
  assign ovf_set_s   = enable_r & full_s & bus.i_sample_valid;
  assign irq_cond_s  = enable_r & (level_s >= thresh_r) & (thresh_r != {(DEPTH_LOG2+1){1'b0}});

  assign bus.o_sample_ready = enable_r & ~full_s;
  assign o_irq              = irq_r;
  assign unused_wdata_s     = ^bus.i_mmio_write_data[30:DEPTH_LOG2+1];

  fifo_fwft #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (32)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_reset_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (flush_s),
    .din   (bus.i_sample_data),
    .head  (head_s),
    .level (level_s),
    .empty (empty_s),
    .full  (full_s)
  );

  // Control registers, sticky overflow (a new drop wins over a same-cycle clear) and irq register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      enable_r   <= 1'b0;
      thresh_r   <= {(DEPTH_LOG2+1){1'b0}};
      overflow_r <= 1'b0;
      irq_r      <= 1'b0;
    end else begin
      if (ctrl_wr_s)   enable_r <= bus.i_mmio_write_data[CTRL_EN_BIT];
      if (thresh_wr_s) thresh_r <= bus.i_mmio_write_data[DEPTH_LOG2:0];
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_wr_s) begin
        overflow_r <= 1'b0;
      end
      irq_r <= irq_cond_s;
    end
  end

  assign flags_s = '{irq: irq_r, overflow: overflow_r, full: full_s, empty: empty_s};

  // Combinational read mux; the bridge samples it in the strobe cycle.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.i_mmio_addr)
      REG_DATA:   rdata_s = empty_s ? 32'd0 : head_s;
      REG_STATUS: rdata_s = pack_status(16'(level_s), flags_s);
      REG_CTRL:   rdata_s = {31'd0, enable_r};
      REG_THRESH: rdata_s = 32'(thresh_r);
      default:    rdata_s = 32'd0;
    endcase
  end

  assign bus.o_mmio_read_data = rdata_s;

endmodule

// File: tb/tb_mmio_sample_fifo_core.sv
// Self-checking bench for mmio_sample_fifo_core: directed scenarios plus randomized traffic against a queue model.
module tb_mmio_sample_fifo_core;
  import mmio_pkg::*;

  localparam int DEPTH = 512;

  logic clk;
  logic rst_n;
  logic irq;
  int   total;
  int   bad;

  mmio_sample_fifo_core_if bus();

  mmio_sample_fifo_core #(.DEPTH_LOG2(9)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus),
    .o_irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] q[$];
  bit          m_en;
  int          m_th;
  bit          m_ovf;
  bit          m_irq;

  // Observed / expected values captured mid-cycle
  logic [31:0] obs_rd, exp_rd;
  logic        obs_rdy, exp_rdy, obs_irq, exp_irq;

  task automatic model_reset();
    q.delete();
    m_en = 0; m_th = 0; m_ovf = 0; m_irq = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 5'd0) begin
      if (q.size() > 0) r = q[0];
    end else if (a == 5'd1) begin
      r = 32'(q.size());
      r[16] = (q.size() == 0);
      r[17] = (q.size() == DEPTH);
      r[18] = m_ovf;
      r[19] = m_irq;
    end else if (a == 5'd2) begin
      r = {31'd0, m_en};
    end else if (a == 5'd3) begin
      r = 32'(m_th);
    end
    return r;
  endfunction

  // Apply one clock edge worth of behaviour from the inputs currently driven.
  task automatic model_step();
    int n;
    bit wr, rd, flush, pop, push, ovf_set, irq_n;
    logic [4:0]  a;
    logic [31:0] wd;
    n  = q.size();
    a  = bus.i_mmio_addr;
    wd = bus.i_mmio_write_data;
    wr = bus.i_mmio_cs && bus.i_mmio_write;
    rd = bus.i_mmio_cs && bus.i_mmio_read;
    flush   = wr && (a == 5'd2) && wd[31];
    pop     = rd && (a == 5'd0) && (n > 0);
    push    = bus.i_sample_valid && m_en && (n < DEPTH);
    ovf_set = m_en && (n == DEPTH) && bus.i_sample_valid;
    irq_n   = m_en && (n >= m_th) && (m_th != 0);
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(bus.i_sample_data);
    end
    if (wr && a == 5'd2) m_en = wd[0];
    if (wr && a == 5'd3) m_th = int'(wd[9:0]);
    if (ovf_set) m_ovf = 1;
    else if (wr && a == 5'd4) m_ovf = 0;
    m_irq = irq_n;
  endtask

  task automatic idle_bus();
    bus.i_mmio_cs = 1'b0; bus.i_mmio_write = 1'b0; bus.i_mmio_read = 1'b0;
    bus.i_mmio_addr = 5'd0; bus.i_mmio_write_data = 32'd0;
    bus.i_sample_valid = 1'b0; bus.i_sample_data = 32'd0;
  endtask

  // Drive one cycle, capture outputs at the falling edge, then advance model and DUT together.
  task automatic cyc(input bit v, input logic [31:0] d, input bit cs, input bit rd, input bit wr,
                     input logic [4:0] a, input logic [31:0] wd);
    bus.i_sample_valid = v; bus.i_sample_data = d;
    bus.i_mmio_cs = cs; bus.i_mmio_read = rd; bus.i_mmio_write = wr;
    bus.i_mmio_addr = a; bus.i_mmio_write_data = wd;
    @(negedge clk);
    obs_rd = bus.o_mmio_read_data; obs_rdy = bus.o_sample_ready; obs_irq = irq;
    exp_rd = model_read(a); exp_rdy = m_en && (q.size() < DEPTH); exp_irq = m_irq;
    @(posedge clk);
    model_step();
    #1;
    idle_bus();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 32'd0, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0001_0000) begin bad++; $display("FAIL reset_status got=%h exp=%h", obs_rd, 32'h0001_0000); end
    total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", obs_rdy); end
    total++; if (obs_irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", obs_irq); end
  endtask

  task automatic test_fifo_order();
    cyc(0, 32'd0, 1, 0, 1, REG_CTRL, 32'd1);
    for (int i = 1; i <= 3; i++) cyc(1, 32'hA5A5_0000 + 32'(i), 0, 0, 0, REG_DATA, 32'd0);
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0000_0003) begin bad++; $display("FAIL order_level got=%h exp=%h", obs_rd, 32'h0000_0003); end
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
      total++; if (obs_rd !== 32'hA5A5_0000 + 32'(i)) begin bad++; $display("FAIL order_data%0d got=%h exp=%h", i, obs_rd, 32'hA5A5_0000 + 32'(i)); end
    end
    cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
    total++; if (obs_rd !== 32'd0) begin bad++; $display("FAIL order_empty_read got=%h exp=0", obs_rd); end
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0001_0000) begin bad++; $display("FAIL order_empty_status got=%h exp=%h", obs_rd, 32'h0001_0000); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) cyc(1, $urandom, 0, 0, 0, REG_DATA, 32'd0);
    cyc(1, 32'hDEAD_BEEF, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0002_0200) begin bad++; $display("FAIL ovf_full_status got=%h exp=%h", obs_rd, 32'h0002_0200); end
    total++; if (obs_rdy !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b exp=0", obs_rdy); end
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0006_0200) begin bad++; $display("FAIL ovf_sticky got=%h exp=%h", obs_rd, 32'h0006_0200); end
    cyc(0, 32'd0, 1, 0, 1, REG_CLEAR, 32'd0);
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0002_0200) begin bad++; $display("FAIL ovf_clear got=%h exp=%h", obs_rd, 32'h0002_0200); end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
      total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL ovf_drain%0d got=%h exp=%h", i, obs_rd, exp_rd); end
    end
    cyc(0, 32'd0, 1, 0, 1, REG_CTRL, 32'h8000_0001);
  endtask

  task automatic test_irq();
    cyc(0, 32'd0, 1, 0, 1, REG_THRESH, 32'd4);
    for (int i = 0; i < 4; i++) cyc(1, $urandom, 0, 0, 0, REG_DATA, 32'd0);
    cyc(0, 32'd0, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_irq !== 1'b0) begin bad++; $display("FAIL irq_lag got=%b exp=0", obs_irq); end
    cyc(0, 32'd0, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_irq !== 1'b1) begin bad++; $display("FAIL irq_rise got=%b exp=1", obs_irq); end
    total++; if (obs_rd !== 32'h0008_0004) begin bad++; $display("FAIL irq_status got=%h exp=%h", obs_rd, 32'h0008_0004); end
    cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
    cyc(0, 32'd0, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_irq !== 1'b1) begin bad++; $display("FAIL irq_hold got=%b exp=1", obs_irq); end
    cyc(0, 32'd0, 0, 0, 0, REG_STATUS, 32'd0);
    total++; if (obs_irq !== 1'b0) begin bad++; $display("FAIL irq_fall got=%b exp=0", obs_irq); end
    cyc(0, 32'd0, 1, 0, 1, REG_THRESH, 32'd0);
    cyc(0, 32'd0, 1, 0, 1, REG_CTRL, 32'h8000_0001);
  endtask

  task automatic test_back_to_back();
    cyc(1, 32'h1111_0000, 0, 0, 0, REG_DATA, 32'd0);
    cyc(1, 32'h1111_0001, 0, 0, 0, REG_DATA, 32'd0);
    cyc(1, 32'h1111_0002, 1, 1, 0, REG_DATA, 32'd0);
    total++; if (obs_rd !== 32'h1111_0000) begin bad++; $display("FAIL b2b_old_head got=%h exp=%h", obs_rd, 32'h1111_0000); end
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0000_0002) begin bad++; $display("FAIL b2b_level got=%h exp=%h", obs_rd, 32'h0000_0002); end
    cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
    total++; if (obs_rd !== 32'h1111_0001) begin bad++; $display("FAIL b2b_next got=%h exp=%h", obs_rd, 32'h1111_0001); end
  endtask

  task automatic test_flush();
    cyc(1, 32'h2222_0000, 0, 0, 0, REG_DATA, 32'd0);
    cyc(1, 32'h2222_0001, 1, 0, 1, REG_CTRL, 32'h8000_0001);
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0001_0000) begin bad++; $display("FAIL flush_status got=%h exp=%h", obs_rd, 32'h0001_0000); end
    cyc(0, 32'd0, 1, 1, 0, REG_CTRL, 32'd0);
    total++; if (obs_rd !== 32'h0000_0001) begin bad++; $display("FAIL flush_ctrl got=%h exp=%h", obs_rd, 32'h0000_0001); end
    cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
    total++; if (obs_rd !== 32'd0) begin bad++; $display("FAIL flush_data got=%h exp=0", obs_rd); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) cyc(1, $urandom, 0, 0, 0, REG_DATA, 32'd0);
    bus.i_sample_valid = 1'b1; bus.i_sample_data = 32'h3333_3333;
    bus.i_mmio_addr = REG_STATUS;
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.o_mmio_read_data !== 32'h0001_0000) begin bad++; $display("FAIL midrst_status got=%h exp=%h", bus.o_mmio_read_data, 32'h0001_0000); end
    total++; if (bus.o_sample_ready !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b exp=0", bus.o_sample_ready); end
    @(posedge clk); #1;
    idle_bus();
    model_reset();
    rst_n = 1'b1;
    cyc(0, 32'd0, 1, 1, 0, REG_DATA, 32'd0);
    total++; if (obs_rd !== 32'd0) begin bad++; $display("FAIL midrst_data got=%h exp=0", obs_rd); end
    cyc(0, 32'd0, 1, 1, 0, REG_STATUS, 32'd0);
    total++; if (obs_rd !== 32'h0001_0000) begin bad++; $display("FAIL midrst_after got=%h exp=%h", obs_rd, 32'h0001_0000); end
  endtask

  task automatic test_random();
    logic [31:0] wd;
    logic [4:0]  a;
    bit          v, cs, rd, wr;
    int          op;
    cyc(0, 32'd0, 1, 0, 1, REG_CTRL, 32'd1);
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      cs = ($urandom_range(0, 9) != 0);
      rd = 0; wr = 0; a = REG_DATA; wd = $urandom;
      op = $urandom_range(0, 19);
      if (op <= 5)       begin rd = 1; a = REG_DATA; end
      else if (op <= 8)  begin rd = 1; a = REG_STATUS; end
      else if (op == 9)  begin rd = 1; a = REG_CTRL; end
      else if (op == 10) begin rd = 1; a = REG_THRESH; end
      else if (op == 11) begin wr = 1; a = REG_THRESH; wd[9:0] = 10'($urandom_range(0, 12)); end
      else if (op == 12) begin wr = 1; a = REG_CLEAR; end
      else if (op == 13) begin
        wr = 1; a = REG_CTRL;
        wd[31] = ($urandom_range(0, 3) == 0);
        wd[0]  = ($urandom_range(0, 5) != 0);
      end
      else if (op == 14) begin rd = 1; a = 5'($urandom_range(5, 31)); end
      else if (op == 15) begin wr = 1; a = 5'($urandom_range(5, 31)); end
      else if (op == 16) begin wr = 1; a = REG_STATUS; end
      else               begin a = 5'($urandom_range(0, 4)); end
      cyc(v, $urandom, cs, rd, wr, a, wd);
      total++; if (obs_rd !== exp_rd) begin bad++; $display("FAIL rand_rdata cyc=%0d addr=%0d got=%h exp=%h", i, a, obs_rd, exp_rd); end
      total++; if (obs_rdy !== exp_rdy) begin bad++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, obs_rdy, exp_rdy); end
      total++; if (obs_irq !== exp_irq) begin bad++; $display("FAIL rand_irq cyc=%0d got=%b exp=%b", i, obs_irq, exp_irq); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_irq();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
